pixel_groups_rr_arbiter: RTL and testbench

Parametrised level-0 pixel grouping and arbitration stage for the EBC sensor array. It tiles a ROWS x COLS polarity-tagged pixel array into GRP_ROWS x GRP_COLS groups and raises one request per group to the higher hierarchy level. Each group snapshots its pending pixels when the higher level enables it, then drains the snapshot round-robin, one event per valid/ready handshake. Granted events leave with global address and polarity.

---
 rtl/pixel_groups_rr_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_pixel_groups_rr_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_groups_rr_arbiter.sv
// Level-0 pixel grouping stage: each group snapshots its pending pixels on enable
// and drains them round-robin, one event per valid/ready handshake.
module pixel_groups_rr_arbiter #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int POLARITY = 2,
    parameter int GRP_ROWS = 2,
    parameter int GRP_COLS = 2
) (
    input  logic                                           clk_i,
    input  logic                                           reset_i,
    input  logic [ROWS-1:0][COLS-1:0][POLARITY-1:0]        req_i,
    input  logic [ROWS/GRP_ROWS-1:0][COLS/GRP_COLS-1:0]    enable_i,
    input  logic                                           ready_i,
    output logic [ROWS/GRP_ROWS-1:0][COLS/GRP_COLS-1:0]    req_o,
    output logic [ROWS-1:0][COLS-1:0]                      gnt_out_o,
    output logic [$clog2(ROWS)-1:0]                        x_add_o,
    output logic [$clog2(COLS)-1:0]                        y_add_o,
    output logic [POLARITY-1:0]                            pol_o,
    output logic                                           valid_o,
    output logic                                           active_o,
    output logic                                           grp_release_o
);

    localparam int unsigned NGR = ROWS / GRP_ROWS;
    localparam int unsigned NGC = COLS / GRP_COLS;
    localparam int unsigned NG  = NGR * NGC;
    localparam int unsigned GSZ = GRP_ROWS * GRP_COLS;
    localparam int unsigned XW  = $clog2(ROWS);
    localparam int unsigned YW  = $clog2(COLS);
    localparam int unsigned PW  = (GSZ > 1) ? $clog2(GSZ) : 1;
    localparam int unsigned GW  = (NG > 1) ? $clog2(NG) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
    typedef logic [GSZ-1:0][POLARITY-1:0] snap_t;

    state_t        state_q [NG];
    state_t        state_d [NG];
    snap_t         snap_q  [NG];
    snap_t         snap_d  [NG];
    snap_t         pix     [NG];
    logic [PW-1:0] ptr_q   [NG];
    logic [PW-1:0] ptr_d   [NG];
    logic [PW-1:0] sel     [NG];
    logic [NG-1:0] pix_any;
    logic [NG-1:0] has_sel;
    logic [NG-1:0] en;
    logic [NG-1:0] req_flat;
    logic          own_vld;
    logic [GW-1:0] own_g;
    logic          fire;

    // Packed [NGR][NGC] flattens so that bit g is group g = gr*NGC + gc.
    assign en    = enable_i;
    assign req_o = req_flat;

    always_comb begin
        for (int unsigned g = 0; g < NG; g++) begin
            pix_any[g] = 1'b0;
            for (int unsigned r = 0; r < GRP_ROWS; r++) begin
                for (int unsigned c = 0; c < GRP_COLS; c++) begin
                    pix[g][r*GRP_COLS+c] = req_i[(g/NGC)*GRP_ROWS+r][(g%NGC)*GRP_COLS+c];
                    pix_any[g] = pix_any[g] | (|req_i[(g/NGC)*GRP_ROWS+r][(g%NGC)*GRP_COLS+c]);
                end
            end
        end
    end

    // Rotating priority: first set entry at or after the pointer, wrapping.
    always_comb begin
        for (int unsigned g = 0; g < NG; g++) begin
            has_sel[g] = 1'b0;
            sel[g]     = '0;
            for (int unsigned k = 0; k < GSZ; k++) begin
                if (!has_sel[g] && (|snap_q[g][(32'(ptr_q[g]) + k) % GSZ])) begin
                    has_sel[g] = 1'b1;
                    sel[g]     = PW'((32'(ptr_q[g]) + k) % GSZ);
                end
            end
        end
    end

    always_comb begin
        own_vld = 1'b0;
        own_g   = '0;
        for (int unsigned g = 0; g < NG; g++) begin
            if (!own_vld && en[g]) begin
                own_vld = 1'b1;
                own_g   = GW'(g);
            end
        end
    end

    always_comb begin
        int unsigned row;
        int unsigned col;
        row           = 0;
        col           = 0;
        valid_o       = 1'b0;
        x_add_o       = '0;
        y_add_o       = '0;
        pol_o         = '0;
        gnt_out_o     = '0;
        grp_release_o = 1'b0;
        fire          = 1'b0;
        if (reset_i && own_vld) begin
            if (state_q[own_g] == GRANT && has_sel[own_g]) begin
                row     = (32'(own_g) / NGC) * GRP_ROWS + 32'(sel[own_g]) / GRP_COLS;
                col     = (32'(own_g) % NGC) * GRP_COLS + 32'(sel[own_g]) % GRP_COLS;
                valid_o = 1'b1;
                x_add_o = XW'(row);
                y_add_o = YW'(col);
                pol_o   = snap_q[own_g][sel[own_g]];
                fire    = ready_i;
                if (ready_i) begin
                    gnt_out_o[row][col] = 1'b1;
                end
            end
            if (state_q[own_g] == RELEASE) begin
                grp_release_o = 1'b1;
            end
        end
    end

    always_comb begin
        req_flat = '0;
        active_o = 1'b0;
        for (int unsigned g = 0; g < NG; g++) begin
            req_flat[g] = reset_i && (state_q[g] == IDLE) && pix_any[g];
            active_o    = active_o | (reset_i && (state_q[g] == GRANT));
        end
    end

    // Only the group owning the output mux may advance in GRANT/RELEASE; others freeze.
    always_comb begin
        for (int unsigned g = 0; g < NG; g++) begin
            state_d[g] = state_q[g];
            snap_d[g]  = snap_q[g];
            ptr_d[g]   = ptr_q[g];
            case (state_q[g])
                IDLE: begin
                    if (en[g] && pix_any[g]) begin
                        snap_d[g]  = pix[g];
                        state_d[g] = GRANT;
                    end
                end
                GRANT: begin
                    if (fire && own_g == GW'(g)) begin
                        snap_d[g][sel[g]] = '0;
                        ptr_d[g]          = PW'((32'(sel[g]) + 1) % GSZ);
                        if (snap_d[g] == '0) begin
                            state_d[g] = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (own_vld && own_g == GW'(g)) begin
                        state_d[g] = IDLE;
                    end
                end
                default: state_d[g] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned g = 0; g < NG; g++) begin
            if (!reset_i) begin
                state_q[g] <= IDLE;
                snap_q[g]  <= '0;
                ptr_q[g]   <= '0;
            end else begin
                state_q[g] <= state_d[g];
                snap_q[g]  <= snap_d[g];
                ptr_q[g]   <= ptr_d[g];
            end
        end
    end

endmodule

// File: tb/tb_pixel_groups_rr_arbiter.sv
// Scoreboard bench for pixel_groups_rr_arbiter: directed bursts push expected events,
// a negedge monitor pops and compares on every handshake or release pulse.
module tb_pixel_groups_rr_arbiter;

    logic                   clk;
    logic                   reset_i;
    logic [7:0][7:0][1:0]   req;
    logic [3:0][3:0]        enable;
    logic                   ready;
    logic [3:0][3:0]        req_o;
    logic [7:0][7:0]        gnt_out_o;
    logic [2:0]             x_add_o;
    logic [2:0]             y_add_o;
    logic [1:0]             pol_o;
    logic                   valid_o;
    logic                   active_o;
    logic                   grp_release_o;

    typedef struct {
        bit         rel;
        int         x;
        int         y;
        logic [1:0] pol;
    } ev_t;

    ev_t sbq[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    pixel_groups_rr_arbiter #(
        .ROWS(8), .COLS(8), .POLARITY(2), .GRP_ROWS(2), .GRP_COLS(2)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .req_i(req),
        .enable_i(enable),
        .ready_i(ready),
        .req_o(req_o),
        .gnt_out_o(gnt_out_o),
        .x_add_o(x_add_o),
        .y_add_o(y_add_o),
        .pol_o(pol_o),
        .valid_o(valid_o),
        .active_o(active_o),
        .grp_release_o(grp_release_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        ev_t         e;
        logic [63:0] eg;
        if (valid_o && ready) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got x=%0d y=%0d pol=%0b, required none (t=%0t)",
                         x_add_o, y_add_o, pol_o, $time);
            end else begin
                e  = sbq.pop_front();
                eg = '0;
                eg[e.x*8+e.y] = 1'b1;
                chk("ev_kind", 64'(0), 64'(e.rel));
                chk("ev_x", 64'(x_add_o), 64'(e.x));
                chk("ev_y", 64'(y_add_o), 64'(e.y));
                chk("ev_pol", 64'(pol_o), 64'(e.pol));
                chk("ev_gnt", gnt_out_o, eg);
            end
        end
        if (grp_release_o) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_release: got pulse, required none (t=%0t)", $time);
            end else begin
                e = sbq.pop_front();
                chk("rel_kind", 64'(1), 64'(e.rel));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(int x, int y, logic [1:0] p);
        ev_t e;
        e.rel = 1'b0;
        e.x   = x;
        e.y   = y;
        e.pol = p;
        sbq.push_back(e);
    endtask

    task automatic exr();
        ev_t e;
        e.rel = 1'b1;
        e.x   = 0;
        e.y   = 0;
        e.pol = '0;
        sbq.push_back(e);
    endtask

    // Group 0 burst: snapshot edge, n handshakes, one release cycle, then idle.
    task automatic burst(int n);
        enable       = '0;
        enable[0][0] = 1'b1;
        ready        = 1'b1;
        step();
        req = '0;
        #1;
        chk("burst_active", 64'(active_o), 64'(1));
        repeat (n) step();
        step();
        enable = '0;
        #1;
        chk("burst_idle_active", 64'(active_o), 64'(0));
        step();
    endtask

    initial begin
        logic [3:0][3:0] exp_req;
        reset_i = 1'b0;
        ready   = 1'b1;
        req     = {$urandom(), $urandom(), $urandom(), $urandom()};
        enable  = 16'($urandom());
        repeat (3) step();
        #1;
        chk("rst_valid", 64'(valid_o), 64'(0));
        chk("rst_gnt", gnt_out_o, 64'(0));
        chk("rst_x", 64'(x_add_o), 64'(0));
        chk("rst_y", 64'(y_add_o), 64'(0));
        chk("rst_pol", 64'(pol_o), 64'(0));
        chk("rst_active", 64'(active_o), 64'(0));
        chk("rst_release", 64'(grp_release_o), 64'(0));
        chk("rst_req_o", 64'(req_o), 64'(0));

        req       = '0;
        req[1][3] = 2'b01;
        enable    = '0;
        step();
        reset_i   = 1'b1;
        step();
        #1;
        exp_req       = '0;
        exp_req[0][1] = 1'b1;
        chk("req_o_after_reset", 64'(req_o), 64'(exp_req));
        req = '0;
        step();

        // Single drain of group 0
        ex(0, 0, 2'b01); ex(1, 1, 2'b10); exr();
        req[0][0] = 2'b01;
        req[1][1] = 2'b10;
        burst(2);
        chk("drain_idle_valid", 64'(valid_o), 64'(0));

        // Backpressure: three stalled cycles
        ex(0, 0, 2'b01); ex(1, 1, 2'b10); exr();
        req[0][0]    = 2'b01;
        req[1][1]    = 2'b10;
        enable       = '0;
        enable[0][0] = 1'b1;
        ready        = 1'b0;
        step();
        req = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_valid", 64'(valid_o), 64'(1));
            chk("bp_x", 64'(x_add_o), 64'(0));
            chk("bp_y", 64'(y_add_o), 64'(0));
            chk("bp_pol", 64'(pol_o), 64'(2'b01));
            chk("bp_gnt", gnt_out_o, 64'(0));
            step();
        end
        ready = 1'b1;
        step();
        step();
        step();
        enable = '0;
        step();

        // Round-robin: full burst, then partial burst ending at index 1, then full
        ex(0, 0, 2'b01); ex(0, 1, 2'b10); ex(1, 0, 2'b11); ex(1, 1, 2'b01); exr();
        req[0][0] = 2'b01; req[0][1] = 2'b10; req[1][0] = 2'b11; req[1][1] = 2'b01;
        burst(4);
        ex(0, 0, 2'b10); ex(0, 1, 2'b11); exr();
        req[0][0] = 2'b10; req[0][1] = 2'b11;
        burst(2);
        ex(1, 0, 2'b11); ex(1, 1, 2'b01); ex(0, 0, 2'b01); ex(0, 1, 2'b10); exr();
        req[0][0] = 2'b01; req[0][1] = 2'b10; req[1][0] = 2'b11; req[1][1] = 2'b01;
        burst(4);

        // Snapshot isolation, pointer at 2 so index 3 drains first
        ex(1, 1, 2'b10); ex(0, 0, 2'b01); exr();
        req[0][0]    = 2'b01;
        req[1][1]    = 2'b10;
        enable       = '0;
        enable[0][0] = 1'b1;
        ready        = 1'b1;
        step();
        req       = '0;
        req[0][1] = 2'b10;
        #1;
        chk("iso_req_o_grant", 64'(req_o[0][0]), 64'(0));
        step();
        step();
        step();
        enable = '0;
        #1;
        chk("iso_req_o_after", 64'(req_o[0][0]), 64'(1));
        req = '0;
        step();

        // Enable drop mid-GRANT, pointer at 1
        ex(1, 0, 2'b11); ex(0, 0, 2'b01); exr();
        req[0][0]    = 2'b01;
        req[1][0]    = 2'b11;
        enable       = '0;
        enable[0][0] = 1'b1;
        ready        = 1'b1;
        step();
        req = '0;
        step();
        enable = '0;
        #1;
        chk("drop_valid", 64'(valid_o), 64'(0));
        chk("drop_gnt", gnt_out_o, 64'(0));
        step();
        #1;
        chk("drop_valid2", 64'(valid_o), 64'(0));
        chk("drop_active", 64'(active_o), 64'(1));
        chk("drop_release", 64'(grp_release_o), 64'(0));
        step();
        enable[0][0] = 1'b1;
        #1;
        chk("resume_valid", 64'(valid_o), 64'(1));
        chk("resume_x", 64'(x_add_o), 64'(0));
        chk("resume_y", 64'(y_add_o), 64'(0));
        chk("resume_pol", 64'(pol_o), 64'(2'b01));
        step();
        step();
        enable = '0;
        step();

        // Multi-hot enable of groups 0 and 3: group 0 owns the outputs
        ex(1, 1, 2'b10); exr(); ex(0, 6, 2'b11); exr();
        req[1][1]    = 2'b10;
        req[0][6]    = 2'b11;
        enable       = '0;
        enable[0][0] = 1'b1;
        enable[0][3] = 1'b1;
        ready        = 1'b0;
        step();
        req = '0;
        #1;
        chk("mh_valid", 64'(valid_o), 64'(1));
        chk("mh_x", 64'(x_add_o), 64'(1));
        chk("mh_y", 64'(y_add_o), 64'(1));
        chk("mh_pol", 64'(pol_o), 64'(2'b10));
        ready = 1'b1;
        step();
        step();
        enable[0][0] = 1'b0;
        step();
        step();
        enable = '0;
        step();

        // Reset in the middle of GRANT discards the snapshot
        req[0][0]    = 2'b01;
        enable       = '0;
        enable[0][0] = 1'b1;
        ready        = 1'b0;
        step();
        req = '0;
        #1;
        chk("rmid_active_before", 64'(active_o), 64'(1));
        reset_i = 1'b0;
        step();
        reset_i = 1'b1;
        #1;
        chk("rmid_active_after", 64'(active_o), 64'(0));
        chk("rmid_valid_after", 64'(valid_o), 64'(0));
        ready = 1'b1;
        step();
        step();
        #1;
        chk("rmid_valid_later", 64'(valid_o), 64'(0));
        enable = '0;
        repeat (3) step();

        chk("sb_empty", 64'(sbq.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
